// File: rtl/accel_pkg.sv
// Shared accelerator types: operation codes, compute types and decode error codes.
package accel_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_COMP  = 2'b11
    } op_code_t;

    typedef enum logic [1:0] {
        COMP_ADD  = 2'b00,
        COMP_MUL  = 2'b01,
        COMP_TANH = 2'b10,
        COMP_RELU = 2'b11
    } comp_type_t;

    // Encoding order doubles as the report code; priority is resolved in the decoder.
    typedef enum logic [1:0] {
        ERR_NONE         = 2'b00,
        ERR_NOP_DATA     = 2'b01,
        ERR_COMP_NOVALID = 2'b10,
        ERR_BAD_UNIT     = 2'b11
    } err_code_t;

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with flush and occupancy. DEPTH must be a power of two >= 2
// so the pointers wrap naturally.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    // A flush suppresses both sides so the pointers land cleanly at zero.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    // Head is read straight from storage; forced to zero when nothing is queued.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cmd_decode_queue.sv
// Decodes control/data words into command fields, classifies errors and buffers
// the decoded commands in a FIFO toward the accelerator units.
module cmd_decode_queue
    import accel_pkg::*;
#(
    parameter int UNIT_ID_W = 2,
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 4,
    parameter int SIZE_W    = 3,
    parameter int DEPTH     = 4,
    parameter int DROP_ERR  = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [UNIT_ID_W+3:0]          in_ctrl,
    input  logic [ADDR_W+SIZE_W:0]        in_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UNIT_ID_W-1:0]          out_unit_id,
    output op_code_t                      out_op,
    output comp_type_t                    out_comp,
    output logic [ADDR_W-1:0]             out_addr,
    output logic                          out_dvalid,
    output logic [SIZE_W-1:0]             out_size,
    output logic [1:0]                    out_err,
    output logic                          err_pulse,
    output logic [1:0]                    err_code,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic [$clog2(DEPTH):0]        level
);

    // Queued command; kept local because its field widths follow the parameters.
    typedef struct packed {
        logic [UNIT_ID_W-1:0] unit_id;
        op_code_t             op;
        comp_type_t           comp;
        logic [ADDR_W-1:0]    addr;
        logic                 dvalid;
        logic [SIZE_W-1:0]    size;
        err_code_t            err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                dec;
    entry_t                head;
    logic [ENTRY_W-1:0]    head_bits;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;
    logic                  is_err;
    logic                  wr_en;
    err_code_t             err_code_q;

    // Field extraction and error classification, purely from the offered word.
    always_comb begin
        dec         = '0;
        dec.unit_id = in_ctrl[UNIT_ID_W+3:4];
        dec.op      = op_code_t'(in_ctrl[3:2]);
        dec.comp    = comp_type_t'(in_ctrl[1:0]);
        dec.addr    = in_data[ADDR_W+SIZE_W:SIZE_W+1];
        dec.dvalid  = in_data[SIZE_W];
        dec.size    = in_data[SIZE_W-1:0];
        dec.err     = ERR_NONE;
        if (int'(dec.unit_id) >= NUM_UNITS)
            dec.err = ERR_BAD_UNIT;
        else if (dec.op == OP_NOP && in_data != '0)
            dec.err = ERR_NOP_DATA;
        else if (dec.op == OP_COMP && !dec.dvalid)
            dec.err = ERR_COMP_NOVALID;
    end

    // Ready does not look at in_valid, and a pop cannot make room for a push in the
    // same cycle, so there is no combinational path from out_ready to in_ready.
    assign in_ready = !fifo_full && !flush;
    assign accept   = in_valid && in_ready;
    assign is_err   = (dec.err != ERR_NONE);
    // A dropped errored command is still accepted, it just never reaches the queue.
    assign wr_en    = accept && !((DROP_ERR != 0) && is_err);

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (dec),
        .rd_en   (out_ready),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign head        = head_bits;
    assign out_valid   = !fifo_empty;
    assign out_unit_id = head.unit_id;
    assign out_op      = head.op;
    assign out_comp    = head.comp;
    assign out_addr    = head.addr;
    assign out_dvalid  = head.dvalid;
    assign out_size    = head.size;
    assign out_err     = head.err;
    assign err_code    = err_code_q;

    // Error strobe, sticky last code and saturating counter; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_count  <= '0;
        end else begin
            err_pulse <= accept && is_err;
            if (accept && is_err) begin
                err_code_q <= dec.err;
                if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
